// File: rtl/decode_queue_if.sv
// Fetch-side and consumer-side handshake bundle for decode_queue.
interface decode_queue_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [9:0]      aluCtrl;
    logic [XLEN-1:0] imm;
    logic [5:0]      selA;
    logic [4:0]      selB;
    logic [5:0]      selOut;
    logic            imm_en;
    logic            mem_rd;
    logic            mem_wr;
    logic            branch;
    logic            jump;
    logic            illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, aluCtrl, imm, selA, selB, selOut,
               imm_en, mem_rd, mem_wr, branch, jump, illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, aluCtrl, imm, selA, selB, selOut,
               imm_en, mem_rd, mem_wr, branch, jump, illegal
    );
endinterface

// File: rtl/decode_queue.sv
// RV32I instruction FIFO followed by a registered decode stage.
// Define DECODE_QUEUE_BYPASS_EN to decode straight into the output register when the FIFO is empty.
module decode_queue #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned QDEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    output logic [$clog2(QDEPTH+1)-1:0]    count,
    decode_queue_if.slave                  bus
);
    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = $clog2(QDEPTH + 1);

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_IMM    = 7'b0010011,
        OP_JALR   = 7'b1100111,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111
    } opcode_e;

    typedef struct packed {
        logic [9:0]      alu_ctrl;
        logic [XLEN-1:0] imm;
        logic [5:0]      sel_a;
        logic [4:0]      sel_b;
        logic [5:0]      sel_out;
        logic            imm_en;
        logic            mem_rd;
        logic            mem_wr;
        logic            branch;
        logic            jump;
        logic            illegal;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] inst);
        dec_t        d;
        logic [31:0] imm32;
        logic [5:0]  rs1;
        logic [5:0]  rd;
        d     = '0;
        imm32 = '0;
        rs1   = {1'b0, inst[19:15]};
        rd    = {1'b0, inst[11:7]};
        // Opcode compare covers inst[1:0] == 2'b11, so compressed encodings fall to default
        case (opcode_e'(inst[6:0]))
            OP_R: begin
                d.sel_a    = rs1;
                d.sel_b    = inst[24:20];
                d.sel_out  = rd;
                d.alu_ctrl = {inst[31:25], inst[14:12]};
            end
            OP_IMM: begin
                d.sel_a   = rs1;
                d.sel_out = rd;
                d.imm_en  = 1'b1;
                if (inst[13:12] == 2'b01) begin
                    d.alu_ctrl = {inst[31:25], inst[14:12]};
                    imm32      = {27'd0, inst[24:20]};
                end else begin
                    d.alu_ctrl = {7'd0, inst[14:12]};
                    imm32      = {{20{inst[31]}}, inst[31:20]};
                end
            end
            OP_JALR, OP_LOAD: begin
                d.sel_a   = rs1;
                d.sel_out = rd;
                d.imm_en  = 1'b1;
                imm32     = {{20{inst[31]}}, inst[31:20]};
                d.jump    = (inst[6:0] == OP_JALR);
                d.mem_rd  = (inst[6:0] == OP_LOAD);
            end
            OP_STORE: begin
                d.sel_a  = rs1;
                d.sel_b  = inst[24:20];
                d.imm_en = 1'b1;
                d.mem_wr = 1'b1;
                imm32    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OP_BRANCH: begin
                d.sel_a    = rs1;
                d.sel_b    = inst[24:20];
                d.alu_ctrl = {7'b0100000, inst[14:12]};
                d.branch   = 1'b1;
                imm32      = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                d.sel_a   = (inst[6:0] == OP_AUIPC) ? 6'h20 : 6'h00;
                d.sel_out = rd;
                d.imm_en  = 1'b1;
                imm32     = {inst[31:12], 12'd0};
            end
            OP_JAL: begin
                d.sel_a   = 6'h20;
                d.sel_out = rd;
                d.imm_en  = 1'b1;
                d.jump    = 1'b1;
                imm32     = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: d.illegal = 1'b1;
        endcase
        d.imm = XLEN'($signed(imm32));
        return d;
    endfunction

    logic [31:0]     instr_mem [QDEPTH];
    logic [XLEN-1:0] pc_mem    [QDEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            out_valid_q;
    logic [XLEN-1:0] pc_q;
    dec_t            dec_q;

    logic push;
    logic out_free;
    logic load;
    logic bypass;
    logic fifo_wr;

    assign bus.in_ready = !reset && !flush && (count != CW'(QDEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    assign out_free     = !out_valid_q || bus.out_ready;
    assign load         = (count != '0) && out_free;
`ifdef DECODE_QUEUE_BYPASS_EN
    assign bypass       = push && (count == '0) && out_free;
`else
    assign bypass       = 1'b0;
`endif
    assign fifo_wr      = push && !bypass;

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            instr_mem[wr_ptr] <= bus.in_instr;
            pc_mem[wr_ptr]    <= bus.in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            dec_q       <= '0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr      <= rd_ptr + 1'b1;
                dec_q       <= decode(instr_mem[rd_ptr]);
                pc_q        <= pc_mem[rd_ptr];
                out_valid_q <= 1'b1;
            end else if (bypass) begin
                dec_q       <= decode(bus.in_instr);
                pc_q        <= bus.in_pc;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            count <= count + CW'(fifo_wr) - CW'(load);
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_pc    = pc_q;
    assign bus.aluCtrl   = dec_q.alu_ctrl;
    assign bus.imm       = dec_q.imm;
    assign bus.selA      = dec_q.sel_a;
    assign bus.selB      = dec_q.sel_b;
    assign bus.selOut    = dec_q.sel_out;
    assign bus.imm_en    = dec_q.imm_en;
    assign bus.mem_rd    = dec_q.mem_rd;
    assign bus.mem_wr    = dec_q.mem_wr;
    assign bus.branch    = dec_q.branch;
    assign bus.jump      = dec_q.jump;
    assign bus.illegal   = dec_q.illegal;
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue in its default (two-cycle latency) build.
module tb_decode_queue;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned QDEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [2:0] count;
    int unsigned total  = 0;
    int unsigned passed = 0;

    always #5 clk = ~clk;

    decode_queue_if #(.XLEN(XLEN)) bus ();

    decode_queue #(.XLEN(XLEN), .QDEPTH(QDEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .count (count),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [9:0]  alu;
        logic [31:0] imm;
        logic [5:0]  a;
        logic [4:0]  b;
        logic [5:0]  o;
        logic [5:0]  fl;   // {imm_en, mem_rd, mem_wr, branch, jump, illegal}
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b1; bus.in_instr = 32'h002081B3; bus.in_pc = 32'h10;
        bus.out_ready = 1'b1;
        tick(); tick();
        total++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", bus.in_ready); else passed++;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); else passed++;
        total++; if (count !== 3'd0) $display("FAIL rst_count got %0d exp 0", count); else passed++;
        total++; if ({bus.out_pc, bus.imm, bus.aluCtrl, bus.selA, bus.selOut} !== '0)
            $display("FAIL rst_outputs got %h/%h/%h exp 0", bus.out_pc, bus.imm, bus.aluCtrl); else passed++;
        reset = 1'b0; bus.in_valid = 1'b0;
        tick();
        total++; if (count !== 3'd0) $display("FAIL rst_no_accept count got %0d exp 0", count); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL post_rst_in_ready got %b exp 1", bus.in_ready); else passed++;
    endtask

    task automatic test_decode_vectors();
        vec_t       v [10];
        logic [5:0] fl;
        v[0] = '{32'h002081B3, 10'h000, 32'h00000000, 6'd1,  5'd2, 6'd3,  6'b000000};
        v[1] = '{32'h00512423, 10'h000, 32'h00000008, 6'd2,  5'd5, 6'd0,  6'b101000};
        v[2] = '{32'hFFF00093, 10'h000, 32'hFFFFFFFF, 6'd0,  5'd0, 6'd1,  6'b100000};
        v[3] = '{32'h40315093, 10'h105, 32'h00000003, 6'd2,  5'd0, 6'd1,  6'b100000};
        v[4] = '{32'hFF9FF0EF, 10'h000, 32'hFFFFFFF8, 6'h20, 5'd0, 6'd1,  6'b100010};
        v[5] = '{32'h80000537, 10'h000, 32'h80000000, 6'd0,  5'd0, 6'd10, 6'b100000};
        v[6] = '{32'hFFC32283, 10'h000, 32'hFFFFFFFC, 6'd6,  5'd0, 6'd5,  6'b110000};
        v[7] = '{32'h00008067, 10'h000, 32'h00000000, 6'd1,  5'd0, 6'd0,  6'b100010};
        v[8] = '{32'h00000000, 10'h000, 32'h00000000, 6'd0,  5'd0, 6'd0,  6'b000001};
        v[9] = '{32'h002081B0, 10'h000, 32'h00000000, 6'd0,  5'd0, 6'd0,  6'b000001};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1; bus.in_instr = v[i].instr; bus.in_pc = 32'h1000 + 32'(4 * i);
            tick();
            bus.in_valid = 1'b0;
            total++; if (bus.out_valid !== 1'b0) $display("FAIL lat_early[%0d] out_valid got %b exp 0", i, bus.out_valid); else passed++;
            tick();
            fl = {bus.imm_en, bus.mem_rd, bus.mem_wr, bus.branch, bus.jump, bus.illegal};
            total++; if (bus.out_valid !== 1'b1) $display("FAIL vec_valid[%0d] got %b exp 1", i, bus.out_valid); else passed++;
            total++; if (bus.out_pc !== 32'h1000 + 32'(4 * i)) $display("FAIL vec_pc[%0d] got %h exp %h", i, bus.out_pc, 32'h1000 + 32'(4 * i)); else passed++;
            total++; if (bus.aluCtrl !== v[i].alu) $display("FAIL vec_alu[%0d] got %h exp %h", i, bus.aluCtrl, v[i].alu); else passed++;
            total++; if (bus.imm !== v[i].imm) $display("FAIL vec_imm[%0d] got %h exp %h", i, bus.imm, v[i].imm); else passed++;
            total++; if (bus.selA !== v[i].a) $display("FAIL vec_selA[%0d] got %h exp %h", i, bus.selA, v[i].a); else passed++;
            total++; if (bus.selB !== v[i].b) $display("FAIL vec_selB[%0d] got %h exp %h", i, bus.selB, v[i].b); else passed++;
            total++; if (bus.selOut !== v[i].o) $display("FAIL vec_selOut[%0d] got %h exp %h", i, bus.selOut, v[i].o); else passed++;
            total++; if (fl !== v[i].fl) $display("FAIL vec_flags[%0d] got %b exp %b", i, fl, v[i].fl); else passed++;
            tick();
            total++; if (bus.out_valid !== 1'b0) $display("FAIL vec_retire[%0d] out_valid got %b exp 0", i, bus.out_valid); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_instr = 32'hFE208EE3; bus.in_pc = 32'h2000;
        tick();
        bus.in_instr = 32'h12345097; bus.in_pc = 32'h2004;
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.out_pc !== 32'h2000 || bus.out_valid !== 1'b1) $display("FAIL beq_pc got %h/%b exp 2000/1", bus.out_pc, bus.out_valid); else passed++;
        total++; if (bus.imm !== 32'hFFFFFFFC) $display("FAIL beq_imm got %h exp fffffffc", bus.imm); else passed++;
        total++; if (bus.aluCtrl !== 10'h100 || bus.branch !== 1'b1) $display("FAIL beq_ctrl got %h/%b exp 100/1", bus.aluCtrl, bus.branch); else passed++;
        total++; if (bus.selA !== 6'd1 || bus.selB !== 5'd2 || bus.selOut !== 6'd0 || bus.imm_en !== 1'b0)
            $display("FAIL beq_sel got %h/%h/%h/%b exp 1/2/0/0", bus.selA, bus.selB, bus.selOut, bus.imm_en); else passed++;
        tick();
        total++; if (bus.out_pc !== 32'h2004 || bus.out_valid !== 1'b1) $display("FAIL auipc_pc got %h/%b exp 2004/1", bus.out_pc, bus.out_valid); else passed++;
        total++; if (bus.imm !== 32'h12345000) $display("FAIL auipc_imm got %h exp 12345000", bus.imm); else passed++;
        total++; if (bus.selA !== 6'h20 || bus.selOut !== 6'd1 || bus.branch !== 1'b0 || bus.imm_en !== 1'b1)
            $display("FAIL auipc_sel got %h/%h/%b/%b exp 20/1/0/1", bus.selA, bus.selOut, bus.branch, bus.imm_en); else passed++;
        tick();
        total++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_drain got %b exp 0", bus.out_valid); else passed++;
    endtask

    task automatic test_capacity();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = (32'(i + 1) << 20) | 32'h00000093;
            bus.in_pc    = 32'h3000 + 32'(4 * i);
            tick();
        end
        bus.in_valid = 1'b0;
        total++; if (count !== 3'd4) $display("FAIL cap_count got %0d exp 4", count); else passed++;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL cap_in_ready got %b exp 0", bus.in_ready); else passed++;
        tick(); tick();
        total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h3000 || bus.imm !== 32'd1)
            $display("FAIL cap_hold got %b/%h/%h exp 1/3000/1", bus.out_valid, bus.out_pc, bus.imm); else passed++;
        total++; if (count !== 3'd4) $display("FAIL cap_hold_count got %0d exp 4", count); else passed++;
        bus.out_ready = 1'b1;
        for (int j = 1; j < 5; j++) begin
            tick();
            total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h3000 + 32'(4 * j) || bus.imm !== 32'(j + 1))
                $display("FAIL cap_order[%0d] got %b/%h/%h exp 1/%h/%h", j, bus.out_valid, bus.out_pc, bus.imm, 32'h3000 + 32'(4 * j), j + 1);
            else passed++;
            total++; if (count !== 3'(4 - j)) $display("FAIL cap_drain_count[%0d] got %0d exp %0d", j, count, 4 - j); else passed++;
        end
        tick();
        total++; if (bus.out_valid !== 1'b0) $display("FAIL cap_empty got %b exp 0", bus.out_valid); else passed++;
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_instr = 32'h00100093; bus.in_pc = 32'h4000 + 32'(4 * i);
            tick();
        end
        total++; if (count !== 3'd2 || bus.out_valid !== 1'b1) $display("FAIL pre_flush got %0d/%b exp 2/1", count, bus.out_valid); else passed++;
        flush = 1'b1; bus.in_instr = 32'h002081B3; bus.in_pc = 32'h4FF0;
        #1;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL flush_in_ready got %b exp 0", bus.in_ready); else passed++;
        tick();
        flush = 1'b0; bus.in_valid = 1'b0;
        total++; if (count !== 3'd0 || bus.out_valid !== 1'b0) $display("FAIL flush_clear got %0d/%b exp 0/0", count, bus.out_valid); else passed++;
        tick(); tick();
        total++; if (count !== 3'd0 || bus.out_valid !== 1'b0) $display("FAIL flush_no_accept got %0d/%b exp 0/0", count, bus.out_valid); else passed++;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_instr = 32'h002081B3; bus.in_pc = 32'h4100;
        tick();
        bus.in_valid = 1'b0;
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h4100 || bus.selOut !== 6'd3 || bus.selB !== 5'd2)
            $display("FAIL post_flush got %b/%h/%h/%h exp 1/4100/3/2", bus.out_valid, bus.out_pc, bus.selOut, bus.selB); else passed++;
        tick();
    endtask

    task automatic test_illegal_reset();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_instr = 32'h00000000; bus.in_pc = 32'h5000;
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        total++; if (bus.illegal !== 1'b1 || bus.out_pc !== 32'h5000 || bus.out_valid !== 1'b1)
            $display("FAIL illegal got %b/%h/%b exp 1/5000/1", bus.illegal, bus.out_pc, bus.out_valid); else passed++;
        total++; if ({bus.aluCtrl, bus.imm, bus.selA, bus.selB, bus.selOut, bus.imm_en, bus.mem_rd, bus.mem_wr, bus.branch, bus.jump} !== '0)
            $display("FAIL illegal_ctrl got %h/%h/%h exp 0", bus.aluCtrl, bus.imm, bus.selOut); else passed++;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1; bus.in_instr = 32'h00500093; bus.in_pc = 32'h5100 + 32'(4 * i);
            tick();
        end
        bus.in_valid = 1'b0;
        total++; if (count !== 3'd2) $display("FAIL pre_reset_count got %0d exp 2", count); else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (bus.out_valid !== 1'b0 || count !== 3'd0) $display("FAIL mid_reset got %b/%0d exp 0/0", bus.out_valid, count); else passed++;
        total++; if ({bus.out_pc, bus.imm, bus.illegal, bus.selOut} !== '0)
            $display("FAIL mid_reset_outputs got %h/%h/%b exp 0", bus.out_pc, bus.imm, bus.illegal); else passed++;
        bus.out_ready = 1'b1;
        tick(); tick(); tick();
        total++; if (bus.out_valid !== 1'b0 || count !== 3'd0) $display("FAIL reset_no_reappear got %b/%0d exp 0/0", bus.out_valid, count); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_decode_vectors();
        test_back_to_back();
        test_capacity();
        test_flush();
        test_illegal_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised, pipelined successor to the single-cycle RV32I decoder.
- An instruction FIFO (depth QDEPTH) with valid/ready input feeds a registered decode stage with valid/ready output.
- Decodes all RV32I base formats (R, OP-IMM, JALR, LOAD, STORE, BRANCH, LUI, AUIPC, JAL) with full sign-extended immediates, memory/branch/jump flags and illegal detection.
- Sits between fetch and register-file/ALU; flush supports taken branches.

Parameters:
XLEN, 32, datapath/immediate/PC width (32 or 64); immediates sign-extend from bit 31.
QDEPTH, 4, FIFO entries; power of two, >=2.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high.
in_valid  in  1  fetch offers instruction.
in_ready  out  1  = !reset && !flush && (count != QDEPTH).
in_instr  in  32  instruction word.
in_pc  in  XLEN  PC of in_instr.
flush  in  1  discard all queued/decoded entries.
out_valid  out  1  decoded entry present.
out_ready  in  1  consumer accepts.
out_pc  out  XLEN  PC of decoded entry.
aluCtrl  out  10  {funct7, funct3} ALU code.
imm  out  XLEN  immediate.
selA  out  6  operand A; bit5=1 selects PC, else {0,rs1}.
selB  out  5  rs2.
selOut  out  6  destination {0,rd}; 0 = no write.
imm_en  out  1  ALU B operand from imm.
mem_rd  out  1  LOAD.
mem_wr  out  1  STORE.
branch  out  1  BRANCH.
jump  out  1  JAL/JALR.
illegal  out  1  unrecognised encoding.
count  out  $clog2(QDEPTH+1)  FIFO occupancy; excludes output register.

Behaviour:
- Reset (sync, high):
  - Pointers and count = 0; out_valid = 0.
  - All decoded outputs and out_pc = 0; in_ready = 0 during reset.
  - Reset mid-stream drops everything; no entry reappears.
- Push: edge with in_valid && in_ready writes {in_instr, in_pc}; count+1.
- Pop/load: output register loads the FIFO head when count != 0 && (!out_valid || out_ready); count-1.
- Handshake:
  - Output entry retires on out_valid && out_ready.
  - If FIFO is empty at that edge, out_valid drops to 0.
- Held outputs: while out_valid && !out_ready, all outputs hold stable.
- Simultaneous push and pop: count unchanged. in_ready does not look ahead to the pop; when full, no push occurs that cycle.
- Capacity: QDEPTH+1 entries total (FIFO plus output register). Order is strictly FIFO; pointers wrap modulo QDEPTH.
- Latency: accept at edge k, output register loads at edge k+1, out_valid seen after edge k+1 (2 cycles minimum).
- Flush:
  - Clears the FIFO (count = 0) and out_valid = 0.
  - Any in_valid that cycle is not accepted.
  - Flush has priority over push/pop; flush and reset together behave as reset.
- Decode (applies to the loaded entry; unlisted fields are 0):
  - R (0110011): selA=rs1, selB=rs2, selOut=rd, aluCtrl={f7,f3}, imm_en=0.
  - OP-IMM (0010011): selA=rs1, selOut=rd, imm_en=1.
    - f3 = 001 or 101: aluCtrl={f7,f3}, imm=zero-extended inst[24:20].
    - Otherwise: aluCtrl={0,f3}, imm=sext(inst[31:20]).
  - JALR (1100111): selA=rs1, selOut=rd, imm=sext(inst[31:20]), aluCtrl=0, imm_en=1, jump=1.
  - LOAD (0000011): as JALR but mem_rd=1, jump=0.
  - STORE (0100011): selA=rs1, selB=rs2, selOut=0, imm=sext({inst[31:25],inst[11:7]}), aluCtrl=0, imm_en=1, mem_wr=1.
  - BRANCH (1100011): selA=rs1, selB=rs2, selOut=0, aluCtrl={0100000,f3}, imm_en=0, branch=1.
    - imm=sext({inst[31],inst[7],inst[30:25],inst[11:8],0}).
  - LUI (0110111): selA=0 (x0), selOut=rd, imm=sext({inst[31:12],12'b0}), aluCtrl=0, imm_en=1.
  - AUIPC (0010111): as LUI but selA=6'h20 (PC).
  - JAL (1101111): selA=6'h20, selOut=rd, imm=sext({inst[31],inst[19:12],inst[20],inst[30:21],0}), imm_en=1, jump=1.
  - Illegal: any other opcode, or inst[1:0] != 11. Set illegal=1, all other controls 0, out_pc valid.

Optional Feature:
- DECODE_QUEUE_BYPASS_EN defined:
  - When count==0 and the output register is free (!out_valid || out_ready), an accepted instruction is decoded straight into the output register at the same edge.
  - FIFO untouched; latency 1 cycle.
  - Ordering preserved: bypass only when the FIFO is empty.
- Undefined: always routed through the FIFO; latency 2.

Test Plan:
- Push 0x002081B3 (add x3,x1,x2), out_ready=1 -> after 2 edges (1 with bypass): aluCtrl=0x000, selA=1, selB=2, selOut=3, imm_en=0, out_valid for one cycle.
- Push 0x00512423 (sw x5,8(x2)) -> imm=8, selA=2, selB=5, selOut=0, mem_wr=1, imm_en=1.
- Push 0xFE208EE3 (beq x1,x2,-4) then 0x12345097 (auipc x1,0x12345):
  - First: imm=0xFFFFFFFC, branch=1, aluCtrl=0x100.
  - Second: imm=0x12345000, selA=0x20, selOut=1.
- out_ready=0, QDEPTH=4, offer 7 instructions -> 5 accepted; count=4, in_ready=0. Release out_ready -> all 5 emerge in order, one per cycle.
- Fill 3 entries, assert flush for one cycle with in_valid=1 -> next cycle count=0, out_valid=0, the offered instruction is not accepted; a subsequent push decodes normally.
- Push 0x00000000 -> illegal=1, all controls 0. Assert reset mid-stream -> all outputs 0 next edge, count=0.
